// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 core: word RAM with a one-cycle registered
// read, a loader port that fills the RAM while the core is held, and access checks.
module lc3_mem_responder #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] dataToMemory,
    input  logic        writeEnable,
    output logic [15:0] dataFromMemory,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        cpu_hold,
    output logic        oob_error,
    output logic [15:0] wr_count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [15:0]          mem_r [DEPTH];
    logic [15:0]          dout_r;
    logic [15:0]          wr_count_r;
    logic                 oob_r;
    logic                 in_run_s;
    logic                 cpu_oob_s;
    logic                 load_oob_s;
    logic                 load_fire_s;
    logic                 load_wr_s;
    logic                 cpu_wr_s;
    logic [ADDR_BITS-1:0] cpu_idx_s;
    logic [ADDR_BITS-1:0] load_idx_s;

    // Any nonzero bit above the RAM index makes the address out of range.
    assign cpu_oob_s   = |address[15:ADDR_BITS];
    assign load_oob_s  = |load_addr[15:ADDR_BITS];
    assign cpu_idx_s   = address[ADDR_BITS-1:0];
    assign load_idx_s  = load_addr[ADDR_BITS-1:0];
    assign in_run_s    = (state_r == ST_RUN);
    assign load_fire_s = !in_run_s && load_valid;
    assign load_wr_s   = load_fire_s && !load_oob_s;
    assign cpu_wr_s    = in_run_s && writeEnable && !cpu_oob_s;

    // Next-state decode: the final loader transfer releases the core for good.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_fire_s && load_last) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // RAM array; deliberately not reset so a loaded image survives a reset.
    always_ff @(posedge clk) begin
        if (load_wr_s) begin
            mem_r[load_idx_s] <= load_data;
        end else if (cpu_wr_s) begin
            mem_r[cpu_idx_s] <= dataToMemory;
        end
    end

    // Registered read port with write-first bypass; zero while loading or out of range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r <= 16'h0000;
        end else if (!in_run_s || cpu_oob_s) begin
            dout_r <= 16'h0000;
        end else if (cpu_wr_s) begin
            dout_r <= dataToMemory;
        end else begin
            dout_r <= mem_r[cpu_idx_s];
        end
    end

    // Saturating count of accepted CPU stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count_r <= 16'h0000;
        end else if (cpu_wr_s && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'd1;
        end
    end

    // Sticky range error from either port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oob_r <= 1'b0;
        end else if ((in_run_s && cpu_oob_s) || (load_fire_s && load_oob_s)) begin
            oob_r <= 1'b1;
        end
    end

    assign dataFromMemory = dout_r;
    assign wr_count       = wr_count_r;
    assign oob_error      = oob_r;
    assign load_ready     = !in_run_s;
    assign cpu_hold       = !in_run_s;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: load sequence, table of CPU accesses,
// reset-during-load, out-of-range load, and store-count saturation.
module tb_lc3_mem_responder;

    logic        clk;
    logic        reset;
    logic [15:0] address;
    logic [15:0] dataToMemory;
    logic        writeEnable;
    logic [15:0] dataFromMemory;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic        load_last;
    logic        cpu_hold;
    logic        oob_error;
    logic [15:0] wr_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_dout;
        logic        exp_oob;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [14];

    lc3_mem_responder #(.ADDR_BITS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .dataToMemory   (dataToMemory),
        .writeEnable    (writeEnable),
        .dataFromMemory (dataFromMemory),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_last      (load_last),
        .cpu_hold       (cpu_hold),
        .oob_error      (oob_error),
        .wr_count       (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [15:0] d);
        writeEnable  = we;
        address      = a;
        dataToMemory = d;
        step();
        writeEnable  = 1'b0;
    endtask

    initial begin
        // addr, we, data -> read data, oob, store count after the edge
        vecs[0]  = '{we: 1'b0, addr: 16'h0001, wdata: 16'h0000, exp_dout: 16'h1021, exp_oob: 1'b0, exp_cnt: 16'd0};
        vecs[1]  = '{we: 1'b0, addr: 16'h0000, wdata: 16'h0000, exp_dout: 16'h5020, exp_oob: 1'b0, exp_cnt: 16'd0};
        vecs[2]  = '{we: 1'b0, addr: 16'h0002, wdata: 16'h0000, exp_dout: 16'h0FFE, exp_oob: 1'b0, exp_cnt: 16'd0};
        vecs[3]  = '{we: 1'b1, addr: 16'h0010, wdata: 16'hBEEF, exp_dout: 16'hBEEF, exp_oob: 1'b0, exp_cnt: 16'd1};
        vecs[4]  = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000, exp_dout: 16'hBEEF, exp_oob: 1'b0, exp_cnt: 16'd1};
        vecs[5]  = '{we: 1'b1, addr: 16'h0020, wdata: 16'h1234, exp_dout: 16'h1234, exp_oob: 1'b0, exp_cnt: 16'd2};
        vecs[6]  = '{we: 1'b0, addr: 16'h0020, wdata: 16'h0000, exp_dout: 16'h1234, exp_oob: 1'b0, exp_cnt: 16'd2};
        vecs[7]  = '{we: 1'b1, addr: 16'h00FF, wdata: 16'h0A0B, exp_dout: 16'h0A0B, exp_oob: 1'b0, exp_cnt: 16'd3};
        vecs[8]  = '{we: 1'b0, addr: 16'h00FF, wdata: 16'h0000, exp_dout: 16'h0A0B, exp_oob: 1'b0, exp_cnt: 16'd3};
        vecs[9]  = '{we: 1'b1, addr: 16'h0100, wdata: 16'hAAAA, exp_dout: 16'h0000, exp_oob: 1'b1, exp_cnt: 16'd3};
        vecs[10] = '{we: 1'b0, addr: 16'h0100, wdata: 16'h0000, exp_dout: 16'h0000, exp_oob: 1'b1, exp_cnt: 16'd3};
        vecs[11] = '{we: 1'b0, addr: 16'h0000, wdata: 16'h0000, exp_dout: 16'h5020, exp_oob: 1'b1, exp_cnt: 16'd3};
        vecs[12] = '{we: 1'b0, addr: 16'h8000, wdata: 16'h0000, exp_dout: 16'h0000, exp_oob: 1'b1, exp_cnt: 16'd3};
        vecs[13] = '{we: 1'b0, addr: 16'h0001, wdata: 16'h0000, exp_dout: 16'h1021, exp_oob: 1'b1, exp_cnt: 16'd3};

        reset        = 1'b0;
        address      = 16'h0001;
        dataToMemory = 16'hFFFF;
        writeEnable  = 1'b1;
        load_valid   = 1'b0;
        load_addr    = 16'h0000;
        load_data    = 16'h0000;
        load_last    = 1'b0;
        step();
        step();
        chk("rst_dout", dataFromMemory, 16'h0000);
        chk("rst_ready", {15'd0, load_ready}, 16'd1);
        chk("rst_hold", {15'd0, cpu_hold}, 16'd1);
        chk("rst_oob", {15'd0, oob_error}, 16'd0);
        chk("rst_cnt", wr_count, 16'd0);
        reset = 1'b1;

        // CPU store strobe is held high during load and must be ignored
        load_word(16'h0000, 16'h5020, 1'b0);
        chk("load_dout_zero", dataFromMemory, 16'h0000);
        load_word(16'h0001, 16'h1021, 1'b0);
        chk("hold_before_last", {15'd0, cpu_hold}, 16'd1);
        load_word(16'h0002, 16'h0FFE, 1'b1);
        chk("hold_after_last", {15'd0, cpu_hold}, 16'd0);
        chk("ready_after_last", {15'd0, load_ready}, 16'd0);
        chk("load_cnt_zero", wr_count, 16'd0);
        writeEnable = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cpu_access(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_dout", i), dataFromMemory, vecs[i].exp_dout);
            chk($sformatf("vec%0d_oob", i), {15'd0, oob_error}, {15'd0, vecs[i].exp_oob});
            chk($sformatf("vec%0d_cnt", i), wr_count, vecs[i].exp_cnt);
        end

        // loader is ignored in RUN
        load_valid = 1'b1;
        load_addr  = 16'h0000;
        load_data  = 16'h1111;
        load_last  = 1'b1;
        cpu_access(1'b0, 16'h0003, 16'h0000);
        load_valid = 1'b0;
        load_last  = 1'b0;
        cpu_access(1'b0, 16'h0000, 16'h0000);
        chk("run_ignores_loader", dataFromMemory, 16'h5020);
        chk("run_stays", {15'd0, cpu_hold}, 16'd0);

        // reset in the middle of a load
        #1 reset = 1'b0;
        #1;
        chk("rst2_oob", {15'd0, oob_error}, 16'd0);
        chk("rst2_cnt", wr_count, 16'd0);
        chk("rst2_hold", {15'd0, cpu_hold}, 16'd1);
        reset = 1'b1;
        load_word(16'h0005, 16'h7777, 1'b0);
        reset = 1'b0;
        step();
        step();
        chk("midload_hold", {15'd0, cpu_hold}, 16'd1);
        chk("midload_cnt", wr_count, 16'd0);
        reset = 1'b1;
        load_word(16'h0006, 16'h6666, 1'b1);
        chk("midload_run", {15'd0, cpu_hold}, 16'd0);
        cpu_access(1'b0, 16'h0005, 16'h0000);
        chk("midload_keep5", dataFromMemory, 16'h7777);
        cpu_access(1'b0, 16'h0006, 16'h0000);
        chk("midload_word6", dataFromMemory, 16'h6666);
        chk("midload_oob", {15'd0, oob_error}, 16'd0);

        // out-of-range final load word: flags error, still completes and releases
        reset = 1'b0;
        step();
        reset = 1'b1;
        load_word(16'h0205, 16'h0BAD, 1'b1);
        chk("oobload_flag", {15'd0, oob_error}, 16'd1);
        chk("oobload_run", {15'd0, cpu_hold}, 16'd0);
        cpu_access(1'b0, 16'h0005, 16'h0000);
        chk("oobload_no_alias", dataFromMemory, 16'h7777);

        // saturation: 65,535 stores reach FFFF, one more holds there
        writeEnable  = 1'b1;
        address      = 16'h0030;
        dataToMemory = 16'h4242;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", wr_count, 16'hFFFE);
        step();
        chk("sat_ffff", wr_count, 16'hFFFF);
        step();
        chk("sat_hold", wr_count, 16'hFFFF);
        writeEnable = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Memory-side responder for the LC-3 style processor core: the slave end of its `address` / `dataToMemory` / `writeEnable` / `dataFromMemory` interface. Holds a word-addressed RAM with a one-cycle registered read, and accepts a program image from a loader port while the core is held off. Sits between the testbench or loader and the processor core. Flags out-of-range accesses and counts CPU stores.

## Interface
- `ADDR_BITS`, 8: RAM depth is 2^ADDR_BITS 16-bit words; legal addresses are 0 to 2^ADDR_BITS-1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  16  CPU word address.
- `dataToMemory`  in  16  CPU store data.
- `writeEnable`  in  1  CPU store strobe; one word per cycle while high.
- `dataFromMemory`  out  16  registered read data to the CPU.
- `load_valid`  in  1  loader word valid.
- `load_ready`  out  1  responder can accept a loader word.
- `load_addr`  in  16  loader word address.
- `load_data`  in  16  loader word data.
- `load_last`  in  1  marks the final loader word; qualified by the transfer.
- `cpu_hold`  out  1  high while loading; the core is held in reset by this signal.
- `oob_error`  out  1  sticky; an access was out of range.
- `wr_count`  out  16  number of accepted in-range CPU stores, saturating.

## Operation
- Two states: LOAD (entered on reset) and RUN. No other state.
- LOAD:
  - `load_ready`=1, `cpu_hold`=1.
  - The CPU port is ignored: no writes, and `dataFromMemory` is held at 0.
  - A transfer occurs on a rising edge with `load_valid`&&`load_ready`. It writes `load_data` to `mem[load_addr]`.
  - A transfer with `load_last`=1 moves the block to RUN on that edge.
- RUN:
  - `load_ready`=0, `cpu_hold`=0, and loader inputs are ignored.
  - Read: every edge, `dataFromMemory` <= `mem[address]`.
  - Write: on an edge with `writeEnable`=1, `mem[address]` <= `dataToMemory`, and `wr_count` increments, saturating at 16'hFFFF.
  - Read-during-write to the same address is write-first: `dataFromMemory` gets `dataToMemory` on that edge.
  - The RUN state is never left except by reset.
- Range check applies to both ports. An address is out of range if `address[15:ADDR_BITS]` != 0 (for the loader, `load_addr`); any nonzero upper bit counts.
  - An out-of-range write is discarded. It does not increment `wr_count`.
  - An out-of-range read returns 16'h0000.
  - In RUN, any CPU access with an out-of-range address sets `oob_error`; this covers every cycle's read address, not only writes.
  - In LOAD, an out-of-range transfer sets `oob_error`. The transfer still completes the handshake, and `load_last` still applies.
  - `oob_error` clears only on reset.
- RAM contents are not cleared by reset. A reset mid-load returns to LOAD, and words already written are retained.

## Timing
- Reset values (asserted asynchronously while `reset`=0):
  - state = LOAD
  - `dataFromMemory` = 16'h0000
  - `load_ready` = 1
  - `cpu_hold` = 1
  - `oob_error` = 0
  - `wr_count` = 0
- `load_ready` and `cpu_hold` are decoded from the registered state.
  - Both change in the cycle after the `load_last` transfer edge.
  - The first CPU read is sampled on the first edge in RUN.
- Read latency is 1 cycle: the address presented before edge k gives data valid after edge k, through to edge k+1.
- A write is visible to a read at the same address sampled on the same edge (write-first) or on any later edge.
- `wr_count` and `oob_error` update on the same edge as the access that causes them.
- Loader throughput is one word per cycle; `load_valid` may be held high continuously.

## Test plan
- Reset then load: three words {0:16'h5020, 1:16'h1021, 2:16'h0FFE}, the last with `load_last`. Required response:
  - `cpu_hold` falls the cycle after the third transfer.
  - Driving `address`=1 returns 16'h1021 one cycle later.
- CPU store: in RUN, `address`=16'h0010, `dataToMemory`=16'hBEEF, `writeEnable`=1 for one cycle. Required response:
  - A read of 16'h0010 returns 16'hBEEF.
  - `wr_count`=1.
- Read-during-write: same cycle write 16'h1234 to 16'h0020 and read 16'h0020 -> `dataFromMemory`=16'h1234 after that edge.
- Out of range: store 16'hAAAA to 16'h0100 (ADDR_BITS=8). Required response:
  - `oob_error`=1 and stays 1.
  - `wr_count` is unchanged.
  - A read of 16'h0100 gives 16'h0000.
  - `mem[0]` is unchanged.
- Reset mid-load: load word 5=16'h7777, assert `reset` for 2 cycles, then load word 6 with `load_last`. Required response:
  - A read of 5 gives 16'h7777.
  - `oob_error`=0 and `wr_count`=0 after reset.
- Saturation: force 65,536 in-range stores -> `wr_count` holds at 16'hFFFF.
